// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch-stage reset/base addresses, bubble instruction,
// next-PC mux select encodings and the fetch-stage control types.
package cpu_defs_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    // Select order of the 4:1 next-PC mux; input 0 is this block's pc_plus4
    localparam logic [1:0] NPC_SEL_PC4    = 2'd0;
    localparam logic [1:0] NPC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] NPC_SEL_JUMP   = 2'd2;
    localparam logic [1:0] NPC_SEL_JR     = 2'd3;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2,
        IFID_FAULT  = 2'd3
    } ifid_op_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: next-PC/hazard/IM-data inputs and PC, IM address and IF/ID outputs.
// Control inputs are level signals sampled on every rising edge; there is no valid/ready
// handshake, and if_id_valid marks whether the IF/ID register holds a real instruction.
interface fetch_pc_unit_if
    import cpu_defs_pkg::*;
#(
    parameter int AW = 10
);
    logic [31:0]  next_pc;
    logic         stall;
    logic         flush;
    logic [31:0]  im_rdata;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [AW-1:0] im_addr;
    logic [31:0]  if_id_instr;
    logic [31:0]  if_id_pc;
    logic [31:0]  if_id_pc8;
    logic         if_id_valid;
    logic         fetch_fault;
    fetch_state_t dbg_state;

    modport master (
        output next_pc, stall, flush, im_rdata,
        input  pc, pc_plus4, im_addr, if_id_instr, if_id_pc, if_id_pc8,
               if_id_valid, fetch_fault, dbg_state
    );

    modport slave (
        input  next_pc, stall, flush, im_rdata,
        output pc, pc_plus4, im_addr, if_id_instr, if_id_pc, if_id_pc8,
               if_id_valid, fetch_fault, dbg_state
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds, loads a fetched instruction, or loads a bubble
// (plain, or tagged with the faulting PC).
module if_id_reg
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  ifid_op_t    op,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc8,
    output logic        if_id_valid
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= 32'd0;
            if_id_pc8   <= 32'd0;
            if_id_valid <= 1'b0;
        end else begin
            case (op)
                IFID_LOAD: begin
                    if_id_instr <= instr;
                    if_id_pc    <= pc;
                    if_id_pc8   <= pc + 32'd8;
                    if_id_valid <= 1'b1;
                end
                IFID_BUBBLE: begin
                    if_id_instr <= NOP_INSTR;
                    if_id_pc    <= 32'd0;
                    if_id_pc8   <= 32'd0;
                    if_id_valid <= 1'b0;
                end
                // Bubble that keeps the faulting address visible for debug
                IFID_FAULT: begin
                    if_id_instr <= NOP_INSTR;
                    if_id_pc    <= pc;
                    if_id_pc8   <= 32'd0;
                    if_id_valid <= 1'b0;
                end
                default: begin
                    if_id_instr <= if_id_instr;
                    if_id_pc    <= if_id_pc;
                    if_id_pc8   <= if_id_pc8;
                    if_id_valid <= if_id_valid;
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC register with IM address generation, sticky fetch-fault
// state machine and the IF/ID pipeline register.
module fetch_pc_unit
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] IM_BASE   = DEF_IM_BASE,
    parameter int          IM_WORDS  = 1024,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic clk,
    input  logic reset,
    fetch_pc_unit_if.slave bus
);

    localparam int AW = $clog2(IM_WORDS);
    // One bit wider so the end bound cannot wrap when IM sits at the top of memory
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

    logic [31:0]  pc_q;
    logic [31:0]  pc_off;
    logic         bad_pc;
    logic         pc_load;
    ifid_op_t     ifid_op;
    fetch_state_t state_q;
    fetch_state_t state_d;

    assign pc_off = pc_q - IM_BASE;
    assign bad_pc = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || ({1'b0, pc_q} >= IM_END);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Fault is only taken on an edge that would otherwise have advanced
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && !bus.stall && bad_pc) begin
            state_d = ST_FAULT;
        end
    end

    always_comb begin
        pc_load = 1'b0;
        ifid_op = IFID_HOLD;
        case (state_q)
            ST_RUN: begin
                if (bus.stall) begin
                    pc_load = 1'b0;
                    ifid_op = IFID_HOLD;
                end else if (bad_pc) begin
                    pc_load = 1'b0;
                    ifid_op = IFID_FAULT;
                end else if (bus.flush) begin
                    pc_load = 1'b1;
                    ifid_op = IFID_BUBBLE;
                end else begin
                    pc_load = 1'b1;
                    ifid_op = IFID_LOAD;
                end
            end
            default: begin
                pc_load = 1'b0;
                ifid_op = IFID_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (pc_load) begin
            pc_q <= bus.next_pc;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_q + 32'd4;
    assign bus.im_addr     = AW'(pc_off >> 2);
    assign bus.fetch_fault = (state_q == ST_FAULT);
    assign bus.dbg_state   = state_q;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .reset       (reset),
        .op          (ifid_op),
        .instr       (bus.im_rdata),
        .pc          (pc_q),
        .if_id_instr (bus.if_id_instr),
        .if_id_pc    (bus.if_id_pc),
        .if_id_pc8   (bus.if_id_pc8),
        .if_id_valid (bus.if_id_valid)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed steps followed by random stall/flush/redirect/reset
// traffic, all checked against a behavioural model of the fetch stage.
module tb_fetch_pc_unit;
    import cpu_defs_pkg::*;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam int          IM_WORDS  = 1024;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          AW        = 10;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] npc;
    logic        st;
    logic        fl;
    logic [31:0] mem [IM_WORDS];

    fetch_pc_unit_if #(.AW(AW)) bus ();

    assign bus.next_pc  = npc;
    assign bus.stall    = st;
    assign bus.flush    = fl;
    assign bus.im_rdata = mem[bus.im_addr];

    fetch_pc_unit #(
        .RESET_PC  (RESET_PC),
        .IM_BASE   (IM_BASE),
        .IM_WORDS  (IM_WORDS),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // reference model state
    logic [31:0] mpc;
    logic        mfault;
    logic [31:0] mi_instr;
    logic [31:0] mi_pc;
    logic [31:0] mi_pc8;
    logic        mi_valid;

    int checks   = 0;
    int failures = 0;

    function automatic bit bad(input logic [31:0] p);
        longint lp;
        lp = longint'(p);
        return (p % 32'd4 != 32'd0) || (lp < longint'(IM_BASE))
            || (lp >= longint'(IM_BASE) + 4 * IM_WORDS);
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            mpc = RESET_PC; mfault = 1'b0;
            mi_instr = NOP_INSTR; mi_pc = 32'd0; mi_pc8 = 32'd0; mi_valid = 1'b0;
        end else if (mfault || st) begin
            // frozen
        end else if (bad(mpc)) begin
            mfault = 1'b1;
            mi_instr = NOP_INSTR; mi_pc = mpc; mi_pc8 = 32'd0; mi_valid = 1'b0;
        end else if (fl) begin
            mi_instr = NOP_INSTR; mi_pc = 32'd0; mi_pc8 = 32'd0; mi_valid = 1'b0;
            mpc = npc;
        end else begin
            mi_instr = mem[(mpc - IM_BASE) / 4];
            mi_pc = mpc; mi_pc8 = mpc + 32'd8; mi_valid = 1'b1;
            mpc = npc;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        chk({step, ".pc"}, bus.pc, mpc);
        chk({step, ".pc_plus4"}, bus.pc_plus4, mpc + 32'd4);
        if (!bad(mpc)) chk({step, ".im_addr"}, 32'(bus.im_addr), (mpc - IM_BASE) / 4);
        chk({step, ".instr"}, bus.if_id_instr, mi_instr);
        chk({step, ".if_pc"}, bus.if_id_pc, mi_pc);
        chk({step, ".if_pc8"}, bus.if_id_pc8, mi_pc8);
        chk({step, ".valid"}, 32'(bus.if_id_valid), 32'(mi_valid));
        chk({step, ".fault"}, 32'(bus.fetch_fault), 32'(mfault));
    endtask

    // driver: inputs are set 1 time unit after an edge, model steps on the edge
    task automatic tick(input string step);
        @(posedge clk);
        model_step();
        #1;
        check_all(step);
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic [31:0] n);
        rst_n = r; st = s; fl = f; npc = n;
    endtask

    initial begin
        for (int i = 0; i < IM_WORDS; i++) mem[i] = $urandom;
        mpc = 32'd0; mfault = 1'b0; mi_instr = 32'd0; mi_pc = 32'd0; mi_pc8 = 32'd0; mi_valid = 1'b0;

        // 1: reset then sequential fetch
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick("t1.rst0");
        tick("t1.rst1");
        chk("t1.reset_pc", bus.pc, 32'h3000);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, mpc + 32'd4);
            tick("t1.seq");
        end
        chk("t1.pc_3008", bus.pc, 32'h3008);
        chk("t1.im_addr_2", 32'(bus.im_addr), 32'd2);

        // 2: stall three cycles, then resume
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0000_5550);
            tick("t2.stall");
        end
        drive(1'b1, 1'b0, 1'b0, mpc + 32'd4);
        tick("t2.resume");
        chk("t2.pc_300c", bus.pc, 32'h300C);

        // 3: flush with redirect
        drive(1'b1, 1'b0, 1'b1, 32'h3100);
        tick("t3.flush");
        chk("t3.pc_3100", bus.pc, 32'h3100);
        drive(1'b1, 1'b0, 1'b0, mpc + 32'd4);
        tick("t3.after");
        chk("t3.instr_3100", bus.if_id_instr, mem[(32'h3100 - IM_BASE) / 4]);

        // 4: stall and flush together at 0x3010
        drive(1'b1, 1'b0, 1'b0, 32'h3010);
        tick("t4.goto");
        drive(1'b1, 1'b1, 1'b1, 32'h3200);
        tick("t4.both");
        drive(1'b1, 1'b0, 1'b0, mpc + 32'd4);
        tick("t4.after");
        chk("t4.valid_after", 32'(bus.if_id_valid), 32'd1);

        // 5: misaligned PC faults and stays frozen until reset
        drive(1'b1, 1'b0, 1'b0, 32'h3002);
        tick("t5.load");
        drive(1'b1, 1'b0, 1'b0, 32'h3400);
        tick("t5.fault");
        chk("t5.fault_pc", bus.if_id_pc, 32'h3002);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i[0], 1'b1, 32'h3500);
            tick("t5.frozen");
        end
        drive(1'b0, 1'b1, 1'b0, 32'h3500);
        tick("t5.reset");

        // 6: IM range boundaries
        drive(1'b1, 1'b0, 1'b0, 32'h4000);
        tick("t6.load_hi");
        drive(1'b1, 1'b0, 1'b0, 32'h3000);
        tick("t6.fault_hi");
        chk("t6.fault_set", 32'(bus.fetch_fault), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick("t6.reset");
        drive(1'b1, 1'b0, 1'b0, 32'h3FFC);
        tick("t6.load_last");
        chk("t6.im_addr_last", 32'(bus.im_addr), 32'd1023);
        drive(1'b1, 1'b0, 1'b0, 32'h3000);
        tick("t6.fetch_last");
        chk("t6.pc8_4004", bus.if_id_pc8, 32'h4004);
        chk("t6.no_fault", 32'(bus.fetch_fault), 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] n;
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 60)      n = mpc + 32'd4;
            else if (sel < 85) n = IM_BASE + 32'($urandom_range(0, IM_WORDS - 1)) * 32'd4;
            else if (sel < 92) n = IM_BASE + 32'($urandom_range(0, 4 * IM_WORDS - 1));
            else               n = $urandom;
            drive(!(mfault ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) < 2)),
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15, n);
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
